// File: rtl/write_order_scheduler.sv
// Write-path scheduler: per-slave AW arbitration, AW-ordered W routing, B return.
// Define WOS_FIXED_PRIO_EN for lowest-index-wins arbiters instead of round-robin.
module write_order_scheduler #(
    parameter int M = 2,
    parameter int S = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH = 4,
    parameter int NUM_OUTSTANDING_TRANS = 2
) (
    input  logic                              clk,
    input  logic                              clr,
    input  logic [M-1:0]                      AW_valid_f,
    input  logic [M*ADDR_WIDTH-1:0]           AW_addr_f,
    input  logic [S-1:0]                      AW_ready_s,
    output logic [M-1:0]                      AW_grant_f,
    output logic [M*$clog2(S)-1:0]            AW_sel_f,
    input  logic [M-1:0]                      W_valid_f,
    input  logic [M-1:0]                      W_last_f,
    input  logic [S-1:0]                      W_ready_s,
    output logic [M-1:0]                      W_grant_f,
    output logic [M*$clog2(S)-1:0]            W_sel_f,
    input  logic [S-1:0]                      B_valid_s,
    input  logic [S*(ID_WIDTH+$clog2(M))-1:0] B_id_s,
    input  logic [M-1:0]                      B_ready_f,
    output logic [S-1:0]                      B_grant_f,
    output logic [S*$clog2(M)-1:0]            B_sel_f,
    output logic [M-1:0]                      outstanding_full
);
    localparam int SW = $clog2(S);
    localparam int MW = $clog2(M);
    localparam int D  = NUM_OUTSTANDING_TRANS;
    localparam int DW = $clog2(D);
    localparam int BW = ID_WIDTH + MW;
    localparam logic [DW:0] DFULL = (DW+1)'(D);

    typedef enum logic {IDLE, GRANT} arb_st_t;

    arb_st_t       aw_st    [S];
    arb_st_t       aw_st_d  [S];
    logic [MW-1:0] aw_own   [S];
    logic [MW-1:0] aw_own_d [S];
    arb_st_t       b_st     [M];
    arb_st_t       b_st_d   [M];
    logic [SW-1:0] b_own    [M];
    logic [SW-1:0] b_own_d  [M];
`ifndef WOS_FIXED_PRIO_EN
    logic [MW-1:0] aw_rr    [S];
    logic [SW-1:0] b_rr     [M];
`endif

    logic [MW-1:0] sf_mem [S][D];
    logic [DW-1:0] sf_rp  [S];
    logic [DW-1:0] sf_wp  [S];
    logic [DW:0]   sf_cnt [S];
    logic [SW-1:0] mf_mem [M][D];
    logic [DW-1:0] mf_rp  [M];
    logic [DW-1:0] mf_wp  [M];
    logic [DW:0]   mf_cnt [M];
    logic [DW:0]   oc     [M];

    logic [SW-1:0] dec       [M];
    logic [SW-1:0] mf_push_s [M];
    logic [M-1:0]  m_busy;
    logic [M-1:0]  mf_push;
    logic [M-1:0]  mf_pop;
    logic [M-1:0]  b_hs;
    logic [S-1:0]  aw_hs;
    logic [S-1:0]  sf_pop;
    logic          unused_bits;

    assign unused_bits = ^{AW_addr_f, B_id_s};

    always_comb begin
        m_busy     = '0;
        aw_hs      = '0;
        mf_push    = '0;
        AW_grant_f = '0;
        AW_sel_f   = '0;
        for (int m = 0; m < M; m++) begin
            dec[m]       = AW_addr_f[m*ADDR_WIDTH+ADDR_WIDTH-1 -: SW];
            mf_push_s[m] = '0;
        end
        for (int s = 0; s < S; s++) begin
            if (aw_st[s] == GRANT) begin
                m_busy[aw_own[s]]            = 1'b1;
                AW_grant_f[aw_own[s]]        = 1'b1;
                AW_sel_f[aw_own[s]*SW +: SW] = SW'(s);
                if (AW_valid_f[aw_own[s]] && AW_ready_s[s]) begin
                    aw_hs[s]             = 1'b1;
                    mf_push[aw_own[s]]   = 1'b1;
                    mf_push_s[aw_own[s]] = SW'(s);
                end
            end
        end
    end

    always_comb begin
        logic [M-1:0] cand;
        int           idx;
        logic         found;
        cand  = '0;
        idx   = 0;
        found = 1'b0;
        for (int s = 0; s < S; s++) begin
            aw_st_d[s]  = aw_st[s];
            aw_own_d[s] = aw_own[s];
            found       = 1'b0;
            for (int m = 0; m < M; m++)
                cand[m] = AW_valid_f[m] && (dec[m] == SW'(s)) &&
                          !m_busy[m] && (oc[m] < DFULL) &&
                          (mf_cnt[m] != DFULL) && (sf_cnt[s] != DFULL);
            unique case (aw_st[s])
                IDLE: begin
                    for (int i = 0; i < M; i++) begin
`ifdef WOS_FIXED_PRIO_EN
                        idx = i;
`else
                        idx = (int'(aw_rr[s]) + 1 + i) % M;
`endif
                        if (!found && cand[idx]) begin
                            found       = 1'b1;
                            aw_st_d[s]  = GRANT;
                            aw_own_d[s] = MW'(idx);
                        end
                    end
                end
                GRANT: if (aw_hs[s]) aw_st_d[s] = IDLE;
                default: ;
            endcase
        end
    end

    // A master drives W only when both order FIFOs agree on the pairing.
    always_comb begin
        logic [SW-1:0] hd;
        hd        = '0;
        W_grant_f = '0;
        W_sel_f   = '0;
        mf_pop    = '0;
        sf_pop    = '0;
        for (int m = 0; m < M; m++) begin
            hd = mf_mem[m][mf_rp[m]];
            if ((mf_cnt[m] != '0) && (sf_cnt[hd] != '0) &&
                (sf_mem[hd][sf_rp[hd]] == MW'(m))) begin
                W_grant_f[m]        = 1'b1;
                W_sel_f[m*SW +: SW] = hd;
                if (W_valid_f[m] && W_ready_s[hd] && W_last_f[m]) begin
                    mf_pop[m]  = 1'b1;
                    sf_pop[hd] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [S-1:0] cand;
        int           idx;
        logic         found;
        cand      = '0;
        idx       = 0;
        found     = 1'b0;
        b_hs      = '0;
        B_grant_f = '0;
        B_sel_f   = '0;
        for (int m = 0; m < M; m++) begin
            b_st_d[m]  = b_st[m];
            b_own_d[m] = b_own[m];
            found      = 1'b0;
            for (int s = 0; s < S; s++)
                cand[s] = B_valid_s[s] &&
                          (B_id_s[s*BW+BW-1 -: MW] == MW'(m));
            unique case (b_st[m])
                IDLE: begin
                    for (int i = 0; i < S; i++) begin
`ifdef WOS_FIXED_PRIO_EN
                        idx = i;
`else
                        idx = (int'(b_rr[m]) + 1 + i) % S;
`endif
                        if (!found && cand[idx]) begin
                            found      = 1'b1;
                            b_st_d[m]  = GRANT;
                            b_own_d[m] = SW'(idx);
                        end
                    end
                end
                GRANT: begin
                    B_grant_f[b_own[m]]         = 1'b1;
                    B_sel_f[b_own[m]*MW +: MW] = MW'(m);
                    if (B_valid_s[b_own[m]] && B_ready_f[m]) begin
                        b_hs[m]   = 1'b1;
                        b_st_d[m] = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb
        for (int m = 0; m < M; m++)
            outstanding_full[m] = (oc[m] == DFULL);

    always_ff @(posedge clk) begin
        for (int s = 0; s < S; s++)
            if (aw_hs[s]) sf_mem[s][sf_wp[s]] <= aw_own[s];
        for (int m = 0; m < M; m++)
            if (mf_push[m]) mf_mem[m][mf_wp[m]] <= mf_push_s[m];
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int s = 0; s < S; s++) begin
                aw_st[s]  <= IDLE;
                aw_own[s] <= '0;
                sf_rp[s]  <= '0;
                sf_wp[s]  <= '0;
                sf_cnt[s] <= '0;
`ifndef WOS_FIXED_PRIO_EN
                aw_rr[s]  <= MW'(M-1);
`endif
            end
            for (int m = 0; m < M; m++) begin
                b_st[m]   <= IDLE;
                b_own[m]  <= '0;
                mf_rp[m]  <= '0;
                mf_wp[m]  <= '0;
                mf_cnt[m] <= '0;
                oc[m]     <= '0;
`ifndef WOS_FIXED_PRIO_EN
                b_rr[m]   <= SW'(S-1);
`endif
            end
        end else begin
            for (int s = 0; s < S; s++) begin
                aw_st[s]  <= aw_st_d[s];
                aw_own[s] <= aw_own_d[s];
                if (aw_hs[s]) sf_wp[s] <= sf_wp[s] + 1'b1;
                if (sf_pop[s]) sf_rp[s] <= sf_rp[s] + 1'b1;
                sf_cnt[s] <= sf_cnt[s] + (DW+1)'(aw_hs[s])
                                       - (DW+1)'(sf_pop[s]);
`ifndef WOS_FIXED_PRIO_EN
                if (aw_hs[s]) aw_rr[s] <= aw_own[s];
`endif
            end
            for (int m = 0; m < M; m++) begin
                b_st[m]  <= b_st_d[m];
                b_own[m] <= b_own_d[m];
                if (mf_push[m]) mf_wp[m] <= mf_wp[m] + 1'b1;
                if (mf_pop[m]) mf_rp[m] <= mf_rp[m] + 1'b1;
                mf_cnt[m] <= mf_cnt[m] + (DW+1)'(mf_push[m])
                                       - (DW+1)'(mf_pop[m]);
                oc[m] <= oc[m] + (DW+1)'(mf_push[m])
                               - (DW+1)'(b_hs[m] && (oc[m] != '0));
`ifndef WOS_FIXED_PRIO_EN
                if (b_hs[m]) b_rr[m] <= b_own[m];
`endif
            end
        end
    end
endmodule

// File: doc/write_order_scheduler.md
Name: write_order_scheduler

Overview:
- Write-path scheduler for the M x S AXI crossbar: arbitrates AW requests per slave, enforces AW-order routing of W bursts, and routes B responses back to the issuing master.
- Drives the crossbar's write-address, write-data and write-response sel/en controls.
- Tracks outstanding writes per master and accepted-AW order in per-slave and per-master order FIFOs.

Parameters:
M, 2, number of masters (>=2)
S, 2, number of slaves (>=2)
ADDR_WIDTH, 32, address width
ID_WIDTH, 4, master-side ID width; slave-side ID is ID_WIDTH+$clog2(M), master index in the top bits
NUM_OUTSTANDING_TRANS, 2, order-FIFO depth and per-master outstanding-write limit (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
clr  in  1  asynchronous active-low reset
AW_valid_f  in  M  AWVALID per master
AW_addr_f  in  M*ADDR_WIDTH  AWADDR per master, master m at [m*ADDR_WIDTH +: ADDR_WIDTH]
AW_ready_s  in  S  AWREADY per slave
AW_grant_f  out  M  write-address enable per master
AW_sel_f  out  M*$clog2(S)  write-address slave select per master
W_valid_f  in  M  WVALID per master
W_last_f  in  M  WLAST per master
W_ready_s  in  S  WREADY per slave
W_grant_f  out  M  write-data enable per master
W_sel_f  out  M*$clog2(S)  write-data slave select per master
B_valid_s  in  S  BVALID per slave
B_id_s  in  S*(ID_WIDTH+$clog2(M))  BID per slave
B_ready_f  in  M  BREADY per master
B_grant_f  out  S  write-response enable per slave
B_sel_f  out  S*$clog2(M)  write-response master select per slave
outstanding_full  out  M  master at its outstanding limit

Behaviour:
- Decode: target slave = AW_addr_f[m][ADDR_WIDTH-1 -: $clog2(S)].
- Reset (clr=0, async): all grants 0, all sels 0, FIFOs empty, outstanding counters 0, RR pointers favour master 0 / slave 0, outstanding_full 0.
- AW arbiter, one per slave, states IDLE/GRANT:
  - IDLE: candidates are masters m with AW_valid_f[m], decode==s, master m not in GRANT at any slave, outstanding[m] < NUM_OUTSTANDING_TRANS, master FIFO m not full, slave FIFO s not full.
  - If any candidate exists, pick round-robin starting after the last winner and register GRANT; AW_grant_f[m]=1 and AW_sel_f[m]=s from the next cycle.
  - GRANT: hold until an edge with AW_valid_f[m] && AW_ready_s[s]. At that edge: push m into slave FIFO s, push s into master FIFO m, increment outstanding[m], update RR pointer, return to IDLE.
  - Minimum two cycles per AW per slave. Grant is held even if AWVALID drops.
- W routing (combinational from registered FIFO heads only):
  - W_grant_f[m]=1 and W_sel_f[m]=s iff master FIFO m non-empty with head s AND slave FIFO s non-empty with head m.
  - Pop both FIFOs at an edge with W_grant_f[m] && W_valid_f[m] && W_ready_s[s] && W_last_f[m]. Non-last beats do not pop.
  - Ordering is deadlock-free by construction: pushes are globally time-ordered.
- B arbiter, one per master, states IDLE/GRANT:
  - Candidates are slaves s with B_valid_s[s] whose top $clog2(M) bits of B_id_s[s] equal m.
  - Round-robin over slaves; register B_grant_f[s]=1 and B_sel_f[s]=m.
  - Hold until an edge with B_valid_s[s] && B_ready_f[m]; at that edge decrement outstanding[m] and return to IDLE.
- outstanding_full[m] = (outstanding[m] == NUM_OUTSTANDING_TRANS), registered counter compare.
- Simultaneous events:
  - AW push and W pop on the same FIFO in one cycle: both occur, count unchanged. Full blocks new grants only; a pending GRANT cannot overflow, since only that grant pushes those FIFOs.
  - AW increment and B decrement on the same master in one cycle: net 0.
- Counter and FIFO pointer arithmetic is modulo depth; counters never wrap past the limit.
- Reset mid-burst discards all state; the crossbar sees all en=0 immediately.

Optional Feature:
- Macro WOS_FIXED_PRIO_EN.
- Defined: AW and B arbiters use fixed priority (lowest index wins) and RR pointers are removed.
- Undefined: round-robin as above.

Test Plan:
- M0 writes 0x0000_0010 (S0), AW_ready_s=1 -> AW_grant_f=01 one cycle after request, AW_sel M0=0; W_grant_f[0]=1 sel 0 after push; pops on 4th beat with WLAST, not before.
- M0 and M1 both request S1 continuously, 3 AWs each -> grants alternate M0,M1,M0,M1 (fixed-prio build: M0 x3 first).
- M0 issues S0 then S1, M1 issues S1 then S0 -> W bursts complete in AW order, no stall longer than one burst, no deadlock.
- M0 issues 2 AWs with no B returned, NUM_OUTSTANDING_TRANS=2 -> outstanding_full[0]=1, third AW never granted; one B handshake -> third AW granted next cycle.
- S0 and S1 assert BVALID with BID top bit 1 simultaneously -> B_grant_f serialises 01 then 10, B_sel=1 both; BREADY low holds grant.
- clr pulsed low during a W burst -> all grant/en outputs 0 asynchronously; FIFOs empty and counters 0 after release.
